inst_fetcher: RTL and testbench

- Front-end stage feeding the issuer.
- Requests 32-bit instruction words from the memory controller one at a time and computes a static next-PC prediction: JAL is taken, everything else is pc+4.
- Buffers fetched {pc, next_pc, inst} tuples in a small FIFO and presents the head to the issuer.
- A reorder-buffer redirect flushes the FIFO and any in-flight fetch, then restarts fetch at the corrected PC.

---
 rtl/inst_fetcher_if.sv | 29 ++
 rtl/inst_fetcher.sv | 141 ++++++++++++++
 tb/tb_inst_fetcher.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus bundle: memory-controller request/response, issuer head port and ROB redirect.
// master = fetcher side, slave = environment (memory controller, issuer, ROB).
interface inst_fetcher_if;
    logic [31:0] addr_to_mem_ctrl;
    logic        valid_to_mem_ctrl;
    logic        ready_from_mem_ctrl;
    logic [31:0] inst_from_mem_ctrl;
    logic        is_any_full;
    logic        ready_to_issuer;
    logic [31:0] pc_to_issuer;
    logic [31:0] next_pc_to_issuer;
    logic [31:0] inst_to_issuer;
    logic        reset_from_rob_bus;
    logic [31:0] target_pc_from_rob_bus;

    modport master (
        output addr_to_mem_ctrl, valid_to_mem_ctrl,
        output ready_to_issuer, pc_to_issuer, next_pc_to_issuer, inst_to_issuer,
        input  ready_from_mem_ctrl, inst_from_mem_ctrl, is_any_full,
        input  reset_from_rob_bus, target_pc_from_rob_bus
    );

    modport slave (
        input  addr_to_mem_ctrl, valid_to_mem_ctrl,
        input  ready_to_issuer, pc_to_issuer, next_pc_to_issuer, inst_to_issuer,
        output ready_from_mem_ctrl, inst_from_mem_ctrl, is_any_full,
        output reset_from_rob_bus, target_pc_from_rob_bus
    );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetcher: one outstanding memory fetch, static JAL-taken prediction,
// {pc, next_pc, inst} FIFO toward the issuer, flushed and restarted by ROB redirects.
module inst_fetcher #(
    parameter int          QUEUE_DEPTH    = 8,
    parameter int          QUEUE_ID_WIDTH = 3,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    inst_fetcher_if.master fif
);
    localparam int                        CW      = QUEUE_ID_WIDTH + 1;
    localparam logic [CW-1:0]             DEPTH_C = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0]             CNT_ONE = CW'(1);
    localparam logic [QUEUE_ID_WIDTH-1:0] PTR_ONE = QUEUE_ID_WIDTH'(1);
    localparam logic [6:0]                OP_JAL  = 7'b1101111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } entry_t;

    state_e                    state_q, state_d;
    logic [31:0]               pc_q, pc_d;
    logic [31:0]               addr_q, addr_d;
    logic                      valid_q, valid_d;
    logic [QUEUE_ID_WIDTH-1:0] head_q, head_d;
    logic [QUEUE_ID_WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]             count_q, count_d;
    entry_t [QUEUE_DEPTH-1:0]  fifo_q, fifo_d;

    logic        redirect;
    logic        mem_ack;
    logic        pop;
    logic        push;
    logic        has_space;
    logic [31:0] jal_imm;
    logic [31:0] npc;

    assign redirect = fif.reset_from_rob_bus;
    assign mem_ack  = fif.ready_from_mem_ctrl;
    assign pop      = (count_q != '0) && !fif.is_any_full && !redirect;

    // Space is judged after this cycle's pop, so a drain and a new request can overlap.
    assign has_space = (count_q - (pop ? CNT_ONE : '0)) < DEPTH_C;

    assign jal_imm = {{11{fif.inst_from_mem_ctrl[31]}}, fif.inst_from_mem_ctrl[31],
                      fif.inst_from_mem_ctrl[19:12], fif.inst_from_mem_ctrl[20],
                      fif.inst_from_mem_ctrl[30:21], 1'b0};
    assign npc     = (fif.inst_from_mem_ctrl[6:0] == OP_JAL) ? pc_q + jal_imm
                                                             : pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fifo_d  = fifo_q;
        push    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!redirect && has_space) begin
                    valid_d = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // The in-flight word belongs to the squashed path; swallow it when it lands.
                    valid_d = 1'b0;
                    state_d = mem_ack ? S_IDLE : S_DISCARD;
                end else if (mem_ack) begin
                    push    = 1'b1;
                    pc_d    = npc;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (mem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            pc_d    = fif.target_pc_from_rob_bus;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                fifo_d[tail_q] = {pc_q, npc, fif.inst_from_mem_ctrl};
                tail_d         = tail_q + PTR_ONE;
            end
            if (pop) head_d = head_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fifo_q  <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fifo_q  <= fifo_d;
        end
    end

    assign fif.addr_to_mem_ctrl  = addr_q;
    assign fif.valid_to_mem_ctrl = valid_q;
    assign fif.ready_to_issuer   = (count_q != '0);
    assign fif.pc_to_issuer      = fifo_q[head_q].pc;
    assign fif.next_pc_to_issuer = fifo_q[head_q].npc;
    assign fif.inst_to_issuer    = fifo_q[head_q].inst;
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based reference model.
module tb_inst_fetcher;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    inst_fetcher_if fif();

    inst_fetcher #(.QUEUE_DEPTH(8), .QUEUE_ID_WIDTH(3), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .fif(fif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } ent_t;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_npc(logic [31:0] pc, logic [31:0] inst);
        int imm;
        if (inst[6:0] != 7'h6F) return pc + 32'd4;
        imm = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096;
        if (inst[31]) imm = imm - (1 << 20);
        return pc + 32'(imm);
    endfunction

    // Reference model: queue of fetched entries plus "request out" / "word is stale" flags.
    ent_t        m_q[$];
    logic [31:0] m_pc, m_addr, m_np;
    bit          m_valid, m_out, m_stale, m_live, m_pop;
    int          m_occ;
    ent_t        m_ent;

    always @(posedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_pc = 32'h0; m_addr = 32'h0;
            m_valid = 0; m_out = 0; m_stale = 0; m_live = 1;
        end else if (rdy && m_live) begin
            m_pop = (m_q.size() != 0) && !fif.is_any_full && !fif.reset_from_rob_bus;
            if (fif.reset_from_rob_bus) begin
                m_q.delete();
                m_pc    = fif.target_pc_from_rob_bus;
                m_valid = 0;
                if (m_out && fif.ready_from_mem_ctrl) begin
                    m_out = 0; m_stale = 0;
                end else if (m_out) begin
                    m_stale = 1;
                end
            end else begin
                m_occ = m_q.size() - (m_pop ? 1 : 0);
                if (m_pop) void'(m_q.pop_front());
                if (m_out) begin
                    if (fif.ready_from_mem_ctrl) begin
                        if (!m_stale) begin
                            m_np  = ref_npc(m_pc, fif.inst_from_mem_ctrl);
                            m_ent = {m_pc, m_np, fif.inst_from_mem_ctrl};
                            m_q.push_back(m_ent);
                            m_pc  = m_np;
                        end
                        m_out = 0; m_stale = 0; m_valid = 0;
                    end
                end else if (m_occ < DEPTH) begin
                    m_out = 1; m_valid = 1; m_addr = m_pc;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live && rst) begin
            chk("ready_to_issuer", fif.ready_to_issuer, (m_q.size() != 0));
            chk("valid_to_mem", fif.valid_to_mem_ctrl, m_valid);
            chk("addr_to_mem", fif.addr_to_mem_ctrl, m_addr);
            if (m_q.size() != 0) begin
                chk("head_pc", fif.pc_to_issuer, m_q[0].pc);
                chk("head_next_pc", fif.next_pc_to_issuer, m_q[0].npc);
                chk("head_inst", fif.inst_to_issuer, m_q[0].inst);
            end
        end
    end

    // Memory controller: latches a request, answers after a delay with a one-cycle pulse.
    bit          mem_busy = 0;
    int          mem_cnt  = 0;
    int          mem_fix  = 0;
    logic [31:0] mem_a;
    logic [31:0] force_w[logic [31:0]];

    function automatic logic [31:0] word_for(logic [31:0] a);
        logic [31:0] w;
        if (force_w.exists(a)) return force_w[a];
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[6:0] = 7'h6F;
        else if (w[6:0] == 7'h6F) w[0] = 1'b0;
        return w;
    endfunction

    always @(negedge clk) begin
        #1;
        fif.ready_from_mem_ctrl = 1'b0;
        if (!rst) begin
            mem_busy = 0;
        end else if (mem_busy) begin
            if (rdy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    fif.ready_from_mem_ctrl = 1'b1;
                    fif.inst_from_mem_ctrl  = word_for(mem_a);
                    mem_busy = 0;
                end
            end
        end else if (fif.valid_to_mem_ctrl) begin
            mem_busy = 1;
            mem_a    = fif.addr_to_mem_ctrl;
            mem_cnt  = (mem_fix > 0) ? mem_fix : int'($urandom_range(1, 4));
        end
    end

    task automatic redirect_to(logic [31:0] t);
        fif.reset_from_rob_bus     = 1'b1;
        fif.target_pc_from_rob_bus = t;
        @(negedge clk);
        fif.reset_from_rob_bus     = 1'b0;
    endtask

    task automatic wait_ready(string name);
        int i = 0;
        while (!fif.ready_to_issuer && i < 200) begin @(negedge clk); i++; end
        chk(name, fif.ready_to_issuer, 1);
    endtask

    task automatic wait_valid(string name);
        int i = 0;
        while (!fif.valid_to_mem_ctrl && i < 200) begin @(negedge clk); i++; end
        chk(name, fif.valid_to_mem_ctrl, 1);
    endtask

    task automatic wait_size(string name, int n);
        int i = 0;
        while (m_q.size() != n && i < 300) begin @(negedge clk); i++; end
        chk(name, m_q.size(), n);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        fif.ready_from_mem_ctrl    = 1'b0;
        fif.inst_from_mem_ctrl     = 32'h0;
        fif.is_any_full            = 1'b0;
        fif.reset_from_rob_bus     = 1'b0;
        fif.target_pc_from_rob_bus = 32'h0;
        repeat (2) @(negedge clk);

        chk("rst_ready", fif.ready_to_issuer, 0);
        chk("rst_valid", fif.valid_to_mem_ctrl, 0);
        chk("rst_addr", fif.addr_to_mem_ctrl, 32'h0);
        chk("rst_pc", fif.pc_to_issuer, 32'h0);
        chk("rst_next_pc", fif.next_pc_to_issuer, 32'h0);
        chk("rst_inst", fif.inst_to_issuer, 32'h0);

        // First fetch from RESET_PC, 3-cycle memory latency.
        force_w[32'h0] = 32'h00000013;
        mem_fix = 3;
        fif.is_any_full = 1'b1;
        rst = 1'b1;
        wait_ready("t1_wait_ready");
        chk("t1_pc", fif.pc_to_issuer, 32'h0);
        chk("t1_next_pc", fif.next_pc_to_issuer, 32'h4);
        chk("t1_inst", fif.inst_to_issuer, 32'h00000013);
        wait_valid("t1_wait_req");
        chk("t1_next_addr", fif.addr_to_mem_ctrl, 32'h4);

        // Forward JAL.
        force_w[32'h100] = 32'h0100006F;
        redirect_to(32'h100);
        wait_ready("t2_wait_ready");
        chk("t2_pc", fif.pc_to_issuer, 32'h100);
        chk("t2_next_pc", fif.next_pc_to_issuer, 32'h110);
        wait_valid("t2_wait_req");
        chk("t2_next_addr", fif.addr_to_mem_ctrl, 32'h110);

        // Backward JAL, offset -4.
        force_w[32'h8] = 32'hFFDFF06F;
        redirect_to(32'h8);
        wait_ready("t3_wait_ready");
        chk("t3_pc", fif.pc_to_issuer, 32'h8);
        chk("t3_next_pc", fif.next_pc_to_issuer, 32'h4);
        wait_valid("t3_wait_req");
        chk("t3_next_addr", fif.addr_to_mem_ctrl, 32'h4);

        // Fill the FIFO under back-pressure, then release for exactly one cycle.
        for (int i = 0; i <= 8; i++) force_w[32'h300 + 32'(4 * i)] = 32'h00000013;
        mem_fix = 1;
        redirect_to(32'h300);
        wait_size("t4_fill", 8);
        repeat (5) @(negedge clk);
        chk("t4_full_no_req", fif.valid_to_mem_ctrl, 0);
        chk("t4_full_ready", fif.ready_to_issuer, 1);
        chk("t4_full_head", fif.pc_to_issuer, 32'h300);
        fif.is_any_full = 1'b0;
        @(negedge clk);
        fif.is_any_full = 1'b1;
        chk("t4_new_req", fif.valid_to_mem_ctrl, 1);
        chk("t4_new_addr", fif.addr_to_mem_ctrl, 32'h320);
        chk("t4_head_after_pop", fif.pc_to_issuer, 32'h304);
        chk("t4_model_count", m_q.size(), 7);

        // Redirect with a fetch in flight; the stale word lands two cycles later.
        force_w[32'h200] = 32'h00000013;
        mem_fix = 2;
        redirect_to(32'h500);
        wait_valid("t5_wait_req");
        chk("t5_req_addr", fif.addr_to_mem_ctrl, 32'h500);
        redirect_to(32'h200);
        repeat (2) @(negedge clk);
        chk("t5_stale_dropped", fif.ready_to_issuer, 0);
        wait_ready("t5_wait_ready");
        chk("t5_pc", fif.pc_to_issuer, 32'h200);
        chk("t5_next_pc", fif.next_pc_to_issuer, 32'h204);

        // Simultaneous push and pop at count 3.
        for (int i = 0; i < 8; i++) force_w[32'h400 + 32'(4 * i)] = 32'h00000013;
        mem_fix = 4;
        redirect_to(32'h400);
        wait_size("t6_count3", 3);
        begin
            int i = 0;
            while (i < 50) begin
                @(negedge clk); #2;
                if (fif.ready_from_mem_ctrl) break;
                i++;
            end
            chk("t6_pulse_seen", fif.ready_from_mem_ctrl, 1);
        end
        fif.is_any_full = 1'b0;
        @(negedge clk);
        fif.is_any_full = 1'b1;
        chk("t6_model_count", m_q.size(), 3);
        chk("t6_ready", fif.ready_to_issuer, 1);
        chk("t6_head", fif.pc_to_issuer, 32'h404);

        // Random traffic.
        mem_fix = 0;
        force_w.delete();
        for (int c = 0; c < 4000; c++) begin
            rdy                        = ($urandom_range(0, 9) != 0);
            fif.is_any_full            = ($urandom_range(0, 1) == 0);
            fif.reset_from_rob_bus     = ($urandom_range(0, 39) == 0);
            fif.target_pc_from_rob_bus = $urandom;
            @(negedge clk);
        end
        rdy = 1'b1;
        fif.reset_from_rob_bus = 1'b0;
        fif.is_any_full = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
